// File: rtl/fir_pkg.sv
// Shared types and default widths for the FIR tap sequencer and its delay line.
package fir_pkg;

    localparam int DATA_W = 24;
    localparam int COEF_W = 16;
    localparam int ACC_W  = 32;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_FLUSH,
        ST_CAPTURE
    } state_t;

    // Address width for a memory of the given depth; never narrower than 1 bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Bus between the sequencer and the external coefficient RAM plus single-MAC tap.
interface fir_tap_sequencer_if #(
    parameter int AW     = 6,
    parameter int DATA_W = fir_pkg::DATA_W,
    parameter int COEF_W = fir_pkg::COEF_W,
    parameter int ACC_W  = fir_pkg::ACC_W
);

    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              tap_audio_en;
    logic              tap_data_en;
    logic [DATA_W-1:0] tap_aud_data;
    logic [COEF_W-1:0] tap_coefficients;
    logic [ACC_W-1:0]  tap_audio_in;

    modport master (
        output coef_addr,
        output tap_audio_en,
        output tap_data_en,
        output tap_aud_data,
        output tap_coefficients,
        input  coef_data,
        input  tap_audio_in
    );

    modport slave (
        input  coef_addr,
        input  tap_audio_en,
        input  tap_data_en,
        input  tap_aud_data,
        input  tap_coefficients,
        output coef_data,
        output tap_audio_in
    );

endinterface

// File: rtl/fir_delay_ram.sv
// Circular sample history: simple dual-port RAM, synchronous read, write-first on collision.
module fir_delay_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 24,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Per accepted sample, streams NUM_TAPS history/coefficient pairs into the external MAC,
// flushes its multiplier pipeline and captures the accumulated result.
module fir_tap_sequencer #(
    parameter int NUM_TAPS     = 64,
    parameter int MULT_LATENCY = 3,
    parameter int DATA_W       = fir_pkg::DATA_W,
    parameter int COEF_W       = fir_pkg::COEF_W,
    parameter int ACC_W        = fir_pkg::ACC_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_en,
    input  logic [DATA_W-1:0]   aud_data_in,
    output logic                ready,
    fir_tap_sequencer_if.master tap,
    output logic [ACC_W-1:0]    audio_out,
    output logic                audio_out_valid,
    output logic                overrun
);

    import fir_pkg::*;

    localparam int AW      = addr_w(NUM_TAPS);
    localparam int CNT_MAX = (NUM_TAPS > MULT_LATENCY) ? NUM_TAPS : MULT_LATENCY;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LAST_TAP   = CW'(NUM_TAPS - 1);
    localparam logic [CW-1:0] LAST_FLUSH = CW'(MULT_LATENCY - 1);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(NUM_TAPS - 1);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [AW-1:0]     coef_addr;
    logic              audio_en;
    logic              data_en;
    logic [COEF_W-1:0] coef_run;

    fir_delay_ram #(
        .DEPTH(NUM_TAPS),
        .WIDTH(DATA_W),
        .AW   (AW)
    ) u_delay (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(rd_ptr),
        .rdata(ram_rdata)
    );

    assign ready    = (state == ST_IDLE);
    assign overrun  = sample_en && !ready && !reset_n;
    assign coef_run = tap.coef_data;

    // Read addresses run one cycle ahead, so tap data is muxed only while RUN consumes it.
    assign tap.coef_addr        = coef_addr;
    assign tap.tap_audio_en     = audio_en;
    assign tap.tap_data_en      = data_en;
    assign tap.tap_aud_data     = (state == ST_RUN) ? ram_rdata : '0;
    assign tap.tap_coefficients = (state == ST_RUN) ? coef_run  : '0;

    always_ff @(posedge clk) begin
        if (reset_n)
            state <= ST_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_waddr = wr_ptr;
        ram_wdata = '0;
        coef_addr = '0;
        audio_en  = 1'b0;
        data_en   = 1'b0;
        case (state)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_waddr = cnt[AW-1:0];
                if (cnt == LAST_TAP)
                    state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (sample_en) begin
                    ram_we    = 1'b1;
                    ram_wdata = aud_data_in;
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                audio_en  = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                data_en   = 1'b1;
                coef_addr = (cnt == LAST_TAP) ? '0 : AW'(cnt + CW'(1));
                if (cnt == LAST_TAP)
                    state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                data_en = 1'b1;
                if (cnt == LAST_FLUSH)
                    state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            cnt             <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            audio_out       <= '0;
            audio_out_valid <= 1'b0;
        end else begin
            audio_out_valid <= 1'b0;
            // cnt is the position within the current state, restarting on every transition.
            if ((state_nxt != state) || (state == ST_IDLE))
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            case (state)
                ST_INIT: begin
                    if (cnt == LAST_TAP)
                        wr_ptr <= '0;
                end
                ST_IDLE: begin
                    if (sample_en) begin
                        rd_ptr <= wr_ptr;
                        wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + AW'(1);
                    end
                end
                ST_CLEAR, ST_RUN: begin
                    rd_ptr <= (rd_ptr == '0) ? LAST_ADDR : rd_ptr - AW'(1);
                end
                ST_CAPTURE: begin
                    audio_out       <= tap.tap_audio_in;
                    audio_out_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Upstream driver for the single-MAC FIR tap (multiplier + accumulator) in the audio path. Holds the sample history in a circular delay line and, per accepted input sample, streams NUM_TAPS sample/coefficient pairs into the tap. It then flushes the multiplier pipeline and captures the accumulated result as one filtered output sample.

## Interface
Parameters:
- NUM_TAPS, 64: filter length; must be at least 2.
- MULT_LATENCY, 3: tap multiplier pipeline depth in data_en-qualified cycles.
- DATA_W, 24: audio sample width.
- COEF_W, 16: coefficient width.
- ACC_W, 32: tap result width.

Ports (AW = $clog2(NUM_TAPS)):
- clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-high reset (the name follows codebase convention; the polarity is high).
- sample_en  in  1  one-cycle strobe: aud_data_in is valid.
- aud_data_in  in  DATA_W  new audio sample.
- ready  out  1  high only in IDLE; a new sample is accepted.
- coef_addr  out  AW  coefficient RAM address; the RAM is external.
- coef_data  in  COEF_W  coefficient RAM read data, 1-cycle read latency.
- tap_audio_en  out  1  accumulator clear strobe to the tap.
- tap_data_en  out  1  tap clock enable (multiplier CE and accumulator CE).
- tap_aud_data  out  DATA_W  sample to the tap multiplier.
- tap_coefficients  out  COEF_W  coefficient to the tap multiplier.
- tap_audio_in  in  ACC_W  tap accumulated result.
- audio_out  out  ACC_W  filtered sample, held until the next capture.
- audio_out_valid  out  1  one-cycle pulse when audio_out updates.
- overrun  out  1  one-cycle pulse when sample_en arrives while not ready.

## Operation
- State machine states: INIT, IDLE, CLEAR, RUN, FLUSH, CAPTURE.
- INIT (entered on reset):
  - Writes zero to delay-line locations 0..NUM_TAPS-1, one per cycle.
  - Then sets wr_ptr=0 and moves to IDLE.
- IDLE:
  - sample_en writes aud_data_in at wr_ptr, advances wr_ptr mod NUM_TAPS, and moves to CLEAR.
- CLEAR:
  - Holds tap_audio_en=1 for exactly 1 cycle.
  - Issues the read for k=0 (delay address newest, coef_addr=0).
- RUN:
  - Lasts NUM_TAPS cycles, k=0..NUM_TAPS-1.
  - tap_data_en=1; tap_aud_data=x[n-k]; tap_coefficients=coef_data for address k.
  - Issues the read for k+1 in the same cycle.
- Delay-line read address for term k: (newest_ptr − k) mod NUM_TAPS, which wraps naturally.
- FLUSH:
  - Lasts MULT_LATENCY cycles with tap_data_en=1, tap_aud_data=0, tap_coefficients=0.
  - This drains the multiplier pipeline, which only advances with CE.
- CAPTURE:
  - Lasts 1 cycle with tap_data_en=0.
  - Registers tap_audio_in into audio_out, then moves to IDLE.
- sample_en in any state other than IDLE:
  - Pulses overrun; the sample is dropped (not written) and the current computation is unaffected.
- sample_en in INIT is also an overrun.
- Arithmetic is done entirely in the tap; this block performs no scaling or truncation of tap_audio_in.

## Timing
- Reset values:
  - Outputs: ready=0, tap_audio_en=0, tap_data_en=0, tap_aud_data=0, tap_coefficients=0, coef_addr=0, audio_out=0, audio_out_valid=0, overrun=0.
  - Internal: wr_ptr=0; state=INIT.
- Reset mid-operation: tap_data_en drops the cycle after reset is sampled; no audio_out_valid is produced for the aborted sample; the block re-runs INIT.
- INIT takes NUM_TAPS cycles; ready rises in cycle NUM_TAPS after reset deasserts.
- Cycle numbering, with sample_en accepted in cycle 0:
  - Cycle 1: CLEAR.
  - Cycles 2..NUM_TAPS+1: RUN.
  - Cycles NUM_TAPS+2..NUM_TAPS+MULT_LATENCY+1: FLUSH.
  - Cycle NUM_TAPS+MULT_LATENCY+2: CAPTURE.
  - Cycle NUM_TAPS+MULT_LATENCY+3: audio_out_valid=1, ready=1.
- Minimum sample period is NUM_TAPS+MULT_LATENCY+3 cycles (70 at defaults).
- The sample written in cycle 0 is readable in cycle 1: a write-then-read on consecutive cycles returns new data.
- coef_addr and the delay-line read address are issued 1 cycle ahead of use; tap_data_en is aligned to the returned data.

## Structure
- Shared package fir_pkg holds:
  - The state enum.
  - The widths DATA_W, COEF_W and ACC_W.
  - An AW helper function.
- Sub-module fir_delay_ram: NUM_TAPS×DATA_W simple dual-port RAM with synchronous read, one write port and one read port.
- All control, pointers and the state machine live in fir_tap_sequencer.

## Test plan
- Reset then idle:
  - Expect ready=0 for 64 cycles, ready=1 at cycle 64, all outputs at their reset values.
  - The first RUN must present tap_aud_data=0 for k=1..63.
- Impulse: coef[k]=k+1; sample 0x000100, then 63 samples of 0.
  - With a behavioural tap model, output m = 0x100·(m+1) for m=0..63, then 0.
- Latency at defaults:
  - sample_en at cycle 0 → tap_audio_en at 1, tap_data_en cycles 2–68, audio_out_valid exactly at cycle 70, ready again at 70.
- Overrun: second sample_en in cycle 10 after acceptance.
  - Expect overrun pulse in cycle 10, output identical to a run with no second strobe, and wr_ptr advanced by one only.
- Wrap: 130 consecutive samples of value i.
  - Sample 129's RUN must present 129 at k=0 and 66 at k=63.
- Reset asserted in RUN cycle 20:
  - tap_data_en=0 next cycle, no audio_out_valid, full INIT rerun, and the delay line reads zero afterwards.
